audio_level_meter: RTL and testbench
====================================

Name: audio_level_meter

Overview:
Parametrised successor of the audio energy visualiser. It computes a sliding-window mean-square level of an offset-binary audio stream with a valid strobe, rather than one sample per clock. It reports the level as an 8-bit thermometer bar or an 8-bit linear value, and adds peak-hold with timed decay and a clip indicator. It sits between the audio sample source (I2S/PWM path) and the LED/display driver.

Parameters:
W, 8, sample width in bits, offset-binary with centre 2^(W-1); legal 8..16.
LOG2_N, 12, log2 of window length N in samples; legal 2..14.
HOLD_SAMPLES, 12000, accepted samples for which peak and clip are held.
DECAY_SAMPLES, 2400, accepted samples between peak decay steps once the hold has expired.
LIN_DECAY_STEP, 8, amount subtracted from peak per decay step in linear mode.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous clear; same effect as rst
in_valid  in  1  audio_in is valid this cycle
audio_in  in  W  sample, offset-binary
mode  in  1  0 = thermometer bar, 1 = linear
out_valid  out  1  one-cycle pulse when level/peak are updated
level  out  8  current level
peak  out  8  held peak, same format as level
clip  out  1  high while a clipped sample is within the hold window

Behaviour:
- Reset (rst asynchronous, or clr at clock edge): level, peak, clip, out_valid = 0; all pipeline valids = 0; ring head = 0; fill counter = 0; accumulator = 0; hold/decay counters = 0. The ring RAM is not cleared.
- Pipeline, fully pipelined, accepts in_valid on every cycle:
  - S1: d = audio_in - 2^(W-1), signed W+1 bits; clip event if audio_in is 0 or 2^W-1.
  - S2: sq = d*d, unsigned, 2W-1 bits (max 2^(2W-2)); issue synchronous RAM read at head.
  - S3: old = (fill < N) ? 0 : ram[head]; acc <= acc - old + sq; acc width is 2W-1+LOG2_N, never wraps. Write ram[head] <= sq; head <= head+1 mod N; fill saturates at N.
  - S4: register level/peak/clip; pulse out_valid.
- Latency: in_valid at edge t gives out_valid high at edge t+4.
- Cycles without in_valid produce no state change in any stage.
- Mean-square: ms = acc >> LOG2_N, truncating.
- Bar mode: level[k] = (ms >= 2^(2W-16+2k)) for k = 0..7. This is 6 dB per bit; bit 7 is set only at full scale.
- Linear mode: level = min(255, ms >> (2W-10)).
- Peak, evaluated on each S4 update:
  - If level >= peak: peak <= level; hold_cnt <= HOLD_SAMPLES; decay_cnt <= DECAY_SAMPLES.
  - Else if hold_cnt != 0: hold_cnt decrements.
  - Else decay_cnt decrements; at 0 apply one decay step and reload DECAY_SAMPLES. Bar mode: peak <= peak >> 1. Linear mode: peak <= max(0, peak - LIN_DECAY_STEP).
- Mode change: mode is sampled at S4. On the update where mode differs from the previous update, peak <= level and hold restarts. Mode changes never cause a transient.
- Clip: a clip event arriving at S4 sets clip = 1 and reloads clip_cnt = HOLD_SAMPLES. clip_cnt decrements per update; clip = 0 when it reaches 0.
- Simultaneous rst/clr and in_valid: reset wins and the sample is dropped.
- Reset mid-stream: in-flight samples are discarded and the warm-up (fill) restarts.

Test Plan:
1. W=8, LOG2_N=4, bar mode: 4 samples of 0 after reset -> acc=65536, ms=4096; level=0x7F, peak=0x7F; clip=1 on 4th out_valid, each out_valid exactly 4 cycles after its in_valid.
2. Continue with 12 more samples of 0 -> level=0xFF. Then 16 samples of 128 -> level reaches 0x00 exactly on the 16th; peak=0xFF held.
3. Linear mode, constant 255 for 16+ samples -> level=252. Constant 0 -> level saturates at 255. Alternating 0/255 -> bar level=0x7F (ms=16256).
4. Peak hold, HOLD_SAMPLES=8, DECAY_SAMPLES=2: 0xFF then silence -> peak=0xFF for 8 updates, then 0x7F, 0x3F, ... every 2 updates to 0. clip drops after 8 updates.
5. in_valid toggled randomly with gaps vs. a reference model -> identical level sequence; no updates during gaps.
6. rst pulsed asynchronously mid-window (between edges) -> outputs 0 immediately. Then 4 samples of 0 -> level=0x7F, proving stale RAM is masked.

Source files
------------

// File: rtl/audio_level_meter.sv
// Sliding-window mean-square level meter with bar/linear output, peak hold/decay and clip flag.
// Latency 4 cycles from accepted sample to out_valid; no backpressure, a sample may be accepted every cycle.
module audio_level_meter #(
  parameter int W              = 8,
  parameter int LOG2_N         = 12,
  parameter int HOLD_SAMPLES   = 12000,
  parameter int DECAY_SAMPLES  = 2400,
  parameter int LIN_DECAY_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] audio_in,
  input  logic         mode,
  output logic         out_valid,
  output logic [7:0]   level,
  output logic [7:0]   peak,
  output logic         clip
);

  localparam int N   = 1 << LOG2_N;
  localparam int SW  = 2 * W - 1;
  localparam int AW  = SW + LOG2_N;
  localparam int HCW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam int DCW = (DECAY_SAMPLES > 0) ? $clog2(DECAY_SAMPLES + 1) : 1;
  localparam logic [W:0] CENTRE = (W + 1)'(1) << (W - 1);

  typedef struct packed {
    logic              v1;
    logic              v2;
    logic              v3;
    logic              c1;
    logic              c2;
    logic              c3;
    logic [LOG2_N-1:0] head;
    logic [LOG2_N:0]   fill;
    logic [AW-1:0]     acc;
    logic              ov;
    logic [7:0]        level;
    logic [7:0]        peak;
    logic              clip;
    logic              mode_q;
    logic [HCW-1:0]    hold;
    logic [HCW-1:0]    clip_cnt;
    logic [DCW-1:0]    decay;
  } st_t;

  st_t s, n;

  logic [W:0]        d1;
  logic [SW-1:0]     sq2;
  logic [SW-1:0]     rd;
  logic [SW-1:0]     ram [N];

  logic [W:0]        abs_d;
  logic [SW-1:0]     mag_x;
  logic [SW-1:0]     old;
  logic [AW-1:0]     acc_nx;
  logic [SW-1:0]     ms;
  logic [7:0]        bar;
  logic [7:0]        lin;
  logic [7:0]        level_nx;
  logic [7:0]        decayed;
  logic [LOG2_N-1:0] rd_addr;
  logic              clip_det;

  assign clip_det = (audio_in == '0) || (audio_in == '1);
  assign abs_d    = d1[W] ? -d1 : d1;
  assign mag_x    = SW'(abs_d);
  assign old      = s.fill[LOG2_N] ? rd : '0;
  assign acc_nx   = s.acc - AW'(old) + AW'(sq2);
  assign ms       = s.acc[AW-1:LOG2_N];

  // The S3 write advances head on the same edge as the S2 read, so look one slot ahead then.
  assign rd_addr  = s.head + LOG2_N'(s.v2);

  for (genvar k = 0; k < 8; k++) begin : g_bar
    assign bar[k] = |ms[SW-1 : 2*W-16+2*k];
  end

  assign lin      = ms[SW-1] ? 8'hFF : ms[SW-2 : SW-9];
  assign level_nx = mode ? lin : bar;
  assign decayed  = mode ? ((s.peak > 8'(LIN_DECAY_STEP)) ? s.peak - 8'(LIN_DECAY_STEP) : 8'h00)
                         : {1'b0, s.peak[7:1]};

  // Ring RAM and datapath registers carry no reset; stale contents are masked by the fill count.
  always_ff @(posedge clk) begin
    if (in_valid) d1 <= {1'b0, audio_in} - CENTRE;
    if (s.v1) begin
      sq2 <= mag_x * mag_x;
      rd  <= ram[rd_addr];
    end
    if (s.v2) ram[s.head] <= sq2;
  end

  always_comb begin
    n    = s;
    n.ov = 1'b0;

    n.v1 = in_valid;
    if (in_valid) n.c1 = clip_det;

    n.v2 = s.v1;
    if (s.v1) n.c2 = s.c1;

    n.v3 = s.v2;
    if (s.v2) begin
      n.c3   = s.c2;
      n.acc  = acc_nx;
      n.head = s.head + LOG2_N'(1);
      if (!s.fill[LOG2_N]) n.fill = s.fill + (LOG2_N + 1)'(1);
    end

    if (s.v3) begin
      n.ov     = 1'b1;
      n.level  = level_nx;
      n.mode_q = mode;

      // A mode switch re-seeds the peak so it never shows a value in the other scale.
      if (mode != s.mode_q || level_nx >= s.peak) begin
        n.peak  = level_nx;
        n.hold  = HCW'(HOLD_SAMPLES);
        n.decay = DCW'(DECAY_SAMPLES);
      end else if (s.hold != '0) begin
        n.hold = s.hold - HCW'(1);
      end else if (s.decay <= DCW'(1)) begin
        n.peak  = decayed;
        n.decay = DCW'(DECAY_SAMPLES);
      end else begin
        n.decay = s.decay - DCW'(1);
      end

      if (s.c3) begin
        n.clip     = 1'b1;
        n.clip_cnt = HCW'(HOLD_SAMPLES);
      end else if (s.clip_cnt != '0) begin
        n.clip_cnt = s.clip_cnt - HCW'(1);
        n.clip     = (s.clip_cnt != HCW'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      s <= '0;
    else if (clr) s <= '0;
    else          s <= n;
  end

  assign out_valid = s.ov;
  assign level     = s.level;
  assign peak      = s.peak;
  assign clip      = s.clip;

endmodule

// File: tb/tb_audio_level_meter.sv
// Randomised and directed bench for audio_level_meter against a window-sum reference model.
module tb_audio_level_meter;

  localparam int HOLD  = 8;
  localparam int DECAY = 2;
  localparam int LIN   = 8;
  localparam int N     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] audio_in = 8'h00;
  logic       mode = 1'b0;
  logic       out_valid;
  logic [7:0] level;
  logic [7:0] peak;
  logic       clip;

  audio_level_meter #(
    .W(8), .LOG2_N(4), .HOLD_SAMPLES(HOLD), .DECAY_SAMPLES(DECAY), .LIN_DECAY_STEP(LIN)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .audio_in(audio_in), .mode(mode),
    .out_valid(out_valid), .level(level), .peak(peak), .clip(clip)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ncount = 0;

  typedef struct {
    int a;
    int cyc;
  } pend_t;

  pend_t pend[$];
  int    win[$];
  int    m_peak, m_hold, m_decay, m_clipcnt, m_clip, m_mode_prev;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    win.delete();
    pend.delete();
    m_peak = 0; m_hold = 0; m_decay = 0; m_clipcnt = 0; m_clip = 0; m_mode_prev = 0;
  endtask

  task automatic model_step(input int a, output int lv, output int pk, output int cl);
    int sq, sum, ms;
    sq = (a - 128) * (a - 128);
    win.push_back(sq);
    if (win.size() > N) void'(win.pop_front());
    sum = 0;
    foreach (win[i]) sum += win[i];
    ms = sum / N;
    if (mode) lv = (ms / 64 > 255) ? 255 : ms / 64;
    else begin
      lv = 0;
      for (int k = 0; k < 8; k++) if (ms >= (1 << (2 * k))) lv |= (1 << k);
    end
    if (int'(mode) != m_mode_prev || lv >= m_peak) begin
      m_peak = lv; m_hold = HOLD; m_decay = DECAY;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      m_decay--;
      if (m_decay <= 0) begin
        m_peak  = mode ? ((m_peak > LIN) ? m_peak - LIN : 0) : m_peak / 2;
        m_decay = DECAY;
      end
    end
    m_mode_prev = int'(mode);
    if (a == 0 || a == 255) begin
      m_clip = 1; m_clipcnt = HOLD;
    end else if (m_clipcnt > 0) begin
      m_clipcnt--;
      if (m_clipcnt == 0) m_clip = 0;
    end
    pk = m_peak;
    cl = m_clip;
  endtask

  always @(negedge clk) begin : mon
    pend_t p;
    int lv, pk, cl;
    ncount++;
    if (out_valid) begin
      if (pend.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        p = pend.pop_front();
        model_step(p.a, lv, pk, cl);
        check("latency", ncount, p.cyc + 4);
        check("level", int'(level), lv);
        check("peak", int'(peak), pk);
        check("clip", int'(clip), cl);
      end
    end
  end

  task automatic drive(input bit v, input int a, input bit c = 1'b0);
    in_valid = v;
    audio_in = 8'(a);
    clr      = c;
    @(posedge clk);
    if (c) model_reset();
    else if (v) pend.push_back('{a, ncount});
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", int'(level), 0);
    check("rst_peak", int'(peak), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_out_valid", int'(out_valid), 0);
    rst = 1'b0;

    // Warm-up: four full-scale-negative samples over a partly filled window
    repeat (4) drive(1'b1, 0);
    idle(5);
    check("t1_level", int'(level), 'h7F);
    check("t1_peak", int'(peak), 'h7F);
    check("t1_clip", int'(clip), 1);

    repeat (12) drive(1'b1, 0);
    idle(5);
    check("t2_full", int'(level), 'hFF);
    repeat (15) drive(1'b1, 128);
    idle(5);
    check("t2_15th", int'(level), 'h3F);
    drive(1'b1, 128);
    idle(5);
    check("t2_16th", int'(level), 0);

    mode = 1'b1;
    repeat (20) drive(1'b1, 255);
    idle(5);
    check("t3_lin255", int'(level), 252);
    repeat (20) drive(1'b1, 0);
    idle(5);
    check("t3_lin0", int'(level), 255);
    mode = 1'b0;
    for (int i = 0; i < 16; i++) drive(1'b1, (i % 2) ? 255 : 0);
    idle(5);
    check("t3_alt", int'(level), 'h7F);

    // Peak hold then stepped decay while the window drains to silence
    repeat (16) drive(1'b1, 0);
    repeat (40) drive(1'b1, 128);
    idle(5);
    check("t4_peak_end", int'(peak), 0);
    check("t4_clip_end", int'(clip), 0);

    for (int r = 0; r < 6; r++) begin
      mode = 1'($urandom_range(0, 1));
      repeat (60) begin
        int a;
        a = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 0 : 255) : int'($urandom_range(0, 255));
        drive($urandom_range(0, 99) < 60, a);
      end
      idle(5);
    end

    // Asynchronous reset between edges with samples in flight
    mode = 1'b0;
    repeat (6) drive(1'b1, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_level", int'(level), 0);
    check("t6_rst_peak", int'(peak), 0);
    check("t6_rst_clip", int'(clip), 0);
    check("t6_rst_out_valid", int'(out_valid), 0);
    model_reset();
    rst = 1'b0;
    repeat (4) drive(1'b1, 0);
    idle(5);
    check("t6_level", int'(level), 'h7F);

    // Synchronous clear coinciding with a valid sample drops it
    repeat (3) drive(1'b1, 0);
    drive(1'b1, 255, 1'b1);
    idle(6);
    check("t7_clr_level", int'(level), 0);
    check("t7_clr_peak", int'(peak), 0);
    check("t7_clr_clip", int'(clip), 0);
    repeat (4) drive(1'b1, 0);
    idle(5);
    check("t7_level", int'(level), 'h7F);

    check("pending_empty", pend.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
